// File: rtl/wts_key_event_generator_if.sv
// -----------------------------------------------------------------------------
// wts_key_event_generator_if
// Bundles the command/register inputs and the key-event outputs of one
// channel's key event generator.
//   master : register-file side (drives commands and timer settings,
//            observes pulses and status)
//   slave  : key event generator side
// Signals:
//   cmd_write      one-clk write strobe
//   cmd_data[2:0]  bit0 key-on, bit1 release, bit2 force-off request
//   reg_gate_time  auto-release delay in active ticks (0 = disabled)
//   reg_tail_time  auto-off delay after release in active ticks (0 = disabled)
//   key_on / key_release / key_off  one-active-period pulses
//   gate_busy      high while a note is held
//   req_pending    high while a captured request awaits issue
// -----------------------------------------------------------------------------
interface wts_key_event_generator_if #(
  parameter int GATE_W = 16,
  parameter int TAIL_W = 16
);
  logic              cmd_write;
  logic [2:0]        cmd_data;
  logic [GATE_W-1:0] reg_gate_time;
  logic [TAIL_W-1:0] reg_tail_time;
  logic              key_on;
  logic              key_release;
  logic              key_off;
  logic              gate_busy;
  logic              req_pending;

  modport master (
    output cmd_write, cmd_data, reg_gate_time, reg_tail_time,
    input  key_on, key_release, key_off, gate_busy, req_pending
  );

  modport slave (
    input  cmd_write, cmd_data, reg_gate_time, reg_tail_time,
    output key_on, key_release, key_off, gate_busy, req_pending
  );
endinterface

// File: rtl/wts_key_event_generator.sv
// -----------------------------------------------------------------------------
// wts_key_event_generator
// Turns CPU key commands into one-shot key_on / key_release / key_off pulses
// for one channel's ADSR envelope generator, with a programmable gate timer
// that releases the note automatically after a set number of active ticks.
//
// Ports:
//   clk     system clock
//   nreset  asynchronous active-low reset
//   active  timing strobe; pulses and timers advance only on active edges
//   bus     wts_key_event_generator_if.slave (commands, timer settings,
//           pulse outputs, gate_busy, req_pending)
//
// Optional feature (macro WTS_KEY_AUTO_OFF_EN):
//   When defined, a tail counter loaded on entry to RELEASED issues key_off
//   automatically reg_tail_time active ticks after the release pulse.
//   When undefined, reg_tail_time is ignored.
// -----------------------------------------------------------------------------
module wts_key_event_generator #(
  parameter int GATE_W = 16,
  parameter int TAIL_W = 16
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       active,
  wts_key_event_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_GATE     = 2'd1,
    S_RELEASED = 2'd2
  } state_t;

  state_t            r_state;
  logic [2:0]        r_pending;
  logic [GATE_W-1:0] r_gate_cnt;
  logic              r_key_on;
  logic              r_key_release;
  logic              r_key_off;
  logic              r_gate_busy;
  logic              r_req_pending;

  // A write landing on an active edge is folded in here so it is issued on
  // that same edge instead of waiting a whole active period.
  logic [2:0]        w_req;
  assign w_req = r_pending | (bus.cmd_write ? bus.cmd_data : 3'b000);

`ifdef WTS_KEY_AUTO_OFF_EN
  logic [TAIL_W-1:0] r_tail_cnt;
`else
  logic              w_tail_unused;
  assign w_tail_unused = ^bus.reg_tail_time;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= S_IDLE;
      r_pending     <= 3'b000;
      r_gate_cnt    <= '0;
      r_key_on      <= 1'b0;
      r_key_release <= 1'b0;
      r_key_off     <= 1'b0;
      r_gate_busy   <= 1'b0;
      r_req_pending <= 1'b0;
`ifdef WTS_KEY_AUTO_OFF_EN
      r_tail_cnt    <= '0;
`endif
    end else if (active) begin
      // Every active edge consumes all pending requests: the winner is
      // issued and lower-priority requests are discarded.
      r_pending     <= 3'b000;
      r_req_pending <= 1'b0;
      r_key_on      <= 1'b0;
      r_key_release <= 1'b0;
      r_key_off     <= 1'b0;

      if (w_req[2]) begin
        r_key_off   <= 1'b1;
        r_state     <= S_IDLE;
        r_gate_cnt  <= '0;
        r_gate_busy <= 1'b0;
`ifdef WTS_KEY_AUTO_OFF_EN
        r_tail_cnt  <= '0;
`endif
      end else if (w_req[0]) begin
        // Key-on (including retrigger) reloads the gate timer from the
        // register; later register changes do not disturb this count.
        r_key_on    <= 1'b1;
        r_state     <= S_GATE;
        r_gate_cnt  <= bus.reg_gate_time;
        r_gate_busy <= 1'b1;
`ifdef WTS_KEY_AUTO_OFF_EN
        r_tail_cnt  <= '0;
`endif
      end else begin
        case (r_state)
          S_GATE: begin
            // A count of 1 means this is the G-th edge after key-on; a
            // count of 0 (gate time 0) never expires.
            if (w_req[1] || (r_gate_cnt == GATE_W'(1))) begin
              r_key_release <= 1'b1;
              r_state       <= S_RELEASED;
              r_gate_cnt    <= '0;
              r_gate_busy   <= 1'b0;
`ifdef WTS_KEY_AUTO_OFF_EN
              r_tail_cnt    <= bus.reg_tail_time;
`endif
            end else if (r_gate_cnt != '0) begin
              r_gate_cnt <= r_gate_cnt - GATE_W'(1);
            end
          end
          S_RELEASED: begin
`ifdef WTS_KEY_AUTO_OFF_EN
            if (r_tail_cnt == TAIL_W'(1)) begin
              r_key_off  <= 1'b1;
              r_state    <= S_IDLE;
              r_tail_cnt <= '0;
            end else if (r_tail_cnt != '0) begin
              r_tail_cnt <= r_tail_cnt - TAIL_W'(1);
            end
`endif
          end
          default: begin
          end
        endcase
      end
    end else begin
      // Between active edges pulses hold and requests only accumulate.
      r_pending     <= w_req;
      r_req_pending <= |w_req;
    end
  end

  assign bus.key_on      = r_key_on;
  assign bus.key_release = r_key_release;
  assign bus.key_off     = r_key_off;
  assign bus.gate_busy   = r_gate_busy;
  assign bus.req_pending = r_req_pending;

endmodule

// File: tb/tb_wts_key_event_generator.sv
module tb_wts_key_event_generator;

  localparam logic [2:0] P_ON  = 3'b001;
  localparam logic [2:0] P_REL = 3'b010;
  localparam logic [2:0] P_OFF = 3'b100;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic active = 1'b0;

  wts_key_event_generator_if #(.GATE_W(16), .TAIL_W(16)) bus ();

  wts_key_event_generator #(.GATE_W(16), .TAIL_W(16)) dut (
    .clk    (clk),
    .nreset (nreset),
    .active (active),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    logic [2:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   ae_cnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (active edge %0d)", name, act_v, exp_v, ae_cnt);
  endtask

  // Drive inputs for the next rising edge.
  task automatic step(input logic act, input logic wr, input logic [2:0] d);
    @(negedge clk);
    active        = act;
    bus.cmd_write = wr;
    bus.cmd_data  = d;
  endtask

  // Expect a pulse on the active edge 'off' active edges from now
  // (off=1 is the upcoming edge when active is currently driven high).
  task automatic expect_pulse(input int off, input logic [2:0] v);
    exp_t e;
    e.edge_n = ae_cnt + off;
    e.vec    = v;
    exp_q.push_back(e);
  endtask

  // Monitor: on each active edge, any pulse presented is matched against
  // the scoreboard queue; an expected pulse that fails to appear is flagged.
  always @(posedge clk) begin
    logic [2:0] pulses;
    exp_t e;
    #1;
    if (active && nreset) begin
      ae_cnt++;
      pulses = {bus.key_off, bus.key_release, bus.key_on};
      check("pulse_onehot0", {31'd0, $onehot0(pulses)}, 32'd1);
      if (pulses != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, pulses}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_edge", ae_cnt, e.edge_n);
          check("pulse_kind", {29'd0, pulses}, {29'd0, e.vec});
          $display("edge %0d: pulse %b (expected %b at edge %0d)", ae_cnt, pulses, e.vec, e.edge_n);
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_n <= ae_cnt) begin
        e = exp_q.pop_front();
        check("missing_pulse", {29'd0, pulses}, {29'd0, e.vec});
      end
    end
  end

  initial begin
    bus.cmd_write     = 1'b0;
    bus.cmd_data      = 3'b000;
    bus.reg_gate_time = 16'd0;
    bus.reg_tail_time = 16'd0;

    // Reset state
    repeat (3) step(0, 0, 3'b000);
    check("rst_key_on", {31'd0, bus.key_on}, 32'd0);
    check("rst_key_release", {31'd0, bus.key_release}, 32'd0);
    check("rst_key_off", {31'd0, bus.key_off}, 32'd0);
    check("rst_gate_busy", {31'd0, bus.gate_busy}, 32'd0);
    check("rst_req_pending", {31'd0, bus.req_pending}, 32'd0);
    nreset = 1'b1;

    // Key-on written while active=0, issued on the later active edge
    step(0, 1, P_ON);
    step(0, 0, 3'b000);
    check("pend_after_write", {31'd0, bus.req_pending}, 32'd1);
    step(0, 0, 3'b000);
    step(1, 0, 3'b000);
    expect_pulse(1, P_ON);
    step(0, 0, 3'b000);
    check("pend_after_issue", {31'd0, bus.req_pending}, 32'd0);
    check("busy_after_on", {31'd0, bus.gate_busy}, 32'd1);
    check("key_on_held", {31'd0, bus.key_on}, 32'd1);
    step(1, 0, 3'b000);
    step(0, 0, 3'b000);
    check("key_on_cleared", {31'd0, bus.key_on}, 32'd0);

    // Gate time 0: no auto-release over 1000 ticks, then explicit release
    repeat (1000) step(1, 0, 3'b000);
    check("busy_gate0_hold", {31'd0, bus.gate_busy}, 32'd1);
    step(1, 1, P_REL);
    expect_pulse(1, P_REL);
    step(0, 0, 3'b000);
    check("busy_after_rel", {31'd0, bus.gate_busy}, 32'd0);

    // Gate time 4 with active every other clock: release at E4
    bus.reg_gate_time = 16'd4;
    step(1, 1, P_ON);
    expect_pulse(1, P_ON);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 3'b000);
      if (i == 3) bus.reg_gate_time = 16'd9;
      if (i == 4) check("busy_before_E4", {31'd0, bus.gate_busy}, 32'd1);
      step(1, 0, 3'b000);
      if (i == 4) expect_pulse(1, P_REL);
    end
    step(0, 0, 3'b000);
    check("busy_after_E4", {31'd0, bus.gate_busy}, 32'd0);
    check("rel_held_E4", {31'd0, bus.key_release}, 32'd1);
    step(1, 0, 3'b000);
    step(0, 0, 3'b000);
    check("rel_cleared_E5", {31'd0, bus.key_release}, 32'd0);

    // All three requests in one strobe: only key_off
    step(0, 1, 3'b111);
    step(1, 0, 3'b000);
    expect_pulse(1, P_OFF);
    repeat (8) step(1, 0, 3'b000);
    check("busy_after_off", {31'd0, bus.gate_busy}, 32'd0);
    check("pend_after_off", {31'd0, bus.req_pending}, 32'd0);

    // Retrigger at E2 with gate 3: release at E5, not E3
    bus.reg_gate_time = 16'd3;
    step(1, 1, P_ON);
    expect_pulse(1, P_ON);
    step(1, 0, 3'b000);
    step(1, 1, P_ON);
    expect_pulse(1, P_ON);
    expect_pulse(4, P_REL);
    repeat (6) step(1, 0, 3'b000);

    // Auto-off: gate 2, tail 5 -> on E0, release E2, off E7 (feature only)
    bus.reg_gate_time = 16'd2;
    bus.reg_tail_time = 16'd5;
    step(1, 1, P_ON);
    expect_pulse(1, P_ON);
    expect_pulse(3, P_REL);
`ifdef WTS_KEY_AUTO_OFF_EN
    expect_pulse(8, P_OFF);
`endif
    repeat (12) step(1, 0, 3'b000);
    check("busy_after_tail", {31'd0, bus.gate_busy}, 32'd0);

    // On + release together: on wins, release discarded
    bus.reg_gate_time = 16'd0;
    step(1, 1, 3'b011);
    expect_pulse(1, P_ON);
    repeat (4) step(1, 0, 3'b000);
    check("busy_on_over_rel", {31'd0, bus.gate_busy}, 32'd1);

    // Reset during GATE with a release pending
    bus.reg_gate_time = 16'd4;
    step(1, 1, P_ON);
    expect_pulse(1, P_ON);
    step(0, 1, P_REL);
    step(0, 0, 3'b000);
    check("pend_before_rst", {31'd0, bus.req_pending}, 32'd1);
    check("key_on_before_rst", {31'd0, bus.key_on}, 32'd1);
    @(posedge clk);
    #2 nreset = 1'b0;
    #1;
    check("midrst_key_on", {31'd0, bus.key_on}, 32'd0);
    check("midrst_gate_busy", {31'd0, bus.gate_busy}, 32'd0);
    check("midrst_req_pending", {31'd0, bus.req_pending}, 32'd0);
    step(0, 0, 3'b000);
    step(0, 0, 3'b000);
    nreset = 1'b1;
    repeat (10) step(1, 0, 3'b000);
    check("post_rst_busy", {31'd0, bus.gate_busy}, 32'd0);

    step(0, 0, 3'b000);
    step(0, 0, 3'b000);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
